// File: rtl/lsu_align_if.sv
// Request, response and data-memory signal bundle for the load/store alignment unit.
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_wmask, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_wmask, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// RV32 load/store alignment unit: splits word-crossing accesses into two word
// accesses, builds byte write masks, and extends load data.
module lsu_align #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input logic        clk,
  input logic        rst,
  lsu_align_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t          state, state_nx;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     r0_q, r1_q;
  logic            err_q;

  logic [1:0]      off;
  logic [2:0]      size;
  logic [3:0]      szmask;
  logic            split;
  logic [AW-1:0]   w0, w1;
  logic [63:0]     d;
  logic [7:0]      m;
  logic            illegal;

  function automatic logic [31:0] extract(input logic [63:0] cat, input logic [1:0] o,
                                          input logic [2:0] f3);
    logic [63:0] sh;
    sh = cat >> {o, 3'b000};
    case (f3)
      3'd0:    extract = {{24{sh[7]}}, sh[7:0]};
      3'd1:    extract = {{16{sh[15]}}, sh[15:0]};
      3'd4:    extract = {24'd0, sh[7:0]};
      3'd5:    extract = {16'd0, sh[15:0]};
      default: extract = sh[31:0];
    endcase
  endfunction

  always_comb begin
    off = addr_q[1:0];
    case (f3_q[1:0])
      2'd0:    begin size = 3'd1; szmask = 4'b0001; end
      2'd1:    begin size = 3'd2; szmask = 4'b0011; end
      default: begin size = 3'd4; szmask = 4'b1111; end
    endcase
    split = ({1'b0, off} + size) > 3'd4;
    w0    = addr_q[AW+1:2];
    w1    = w0 + AW'(1);
    d     = {32'd0, wdata_q} << {off, 3'b000};
    m     = {4'd0, szmask} << off;
  end

  assign illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                              : (bus.req_funct3 == 3'd3 || bus.req_funct3 > 3'd5);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wmask  = '0;
    bus.mem_we     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = illegal ? DONE : ACC0;
      end
      ACC0: begin
        bus.mem_addr = 32'(w0);
        if (we_q) begin
          bus.mem_wdata = d[31:0];
          bus.mem_wmask = m[3:0];
          bus.mem_we    = 1'b1;
        end
        state_nx = split ? ACC1 : DONE;
      end
      ACC1: begin
        bus.mem_addr = 32'(w1);
        if (we_q) begin
          bus.mem_wdata = d[63:32];
          bus.mem_wmask = m[7:4];
          bus.mem_we    = 1'b1;
        end
        state_nx = DONE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        // r0/r1 are cleared on accept, so stores and unsplit loads see zero upper bytes
        if (!we_q && !err_q) bus.resp_rdata = extract({r1_q, r0_q}, off, f3_q);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Keep memory quiet during reset so no write commits on a reset edge
    if (!rst) begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_wmask  = '0;
      bus.mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          f3_q    <= bus.req_funct3;
          addr_q  <= bus.req_addr[AW+1:0];
          wdata_q <= bus.req_wdata;
          err_q   <= illegal;
          r0_q    <= '0;
          r1_q    <= '0;
        end
        ACC0: if (!we_q) r0_q <= bus.mem_rdata;
        ACC1: if (!we_q) r1_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align against a byte-addressed memory model.
module tb_lsu_align;
  localparam int unsigned MS = 1024;
  localparam int unsigned AW = $clog2(MS);
  localparam int unsigned NB = 4 * MS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_align_if bus ();
  lsu_align #(.MEM_SIZE(MS)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [MS];
  logic        ld_en = 1'b0;
  logic [AW-1:0] ld_idx = '0;
  logic [31:0] ld_val = '0;
  logic [7:0]  rb [NB];

  assign bus.mem_rdata = mem[bus.mem_addr[AW-1:0]];
  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) mem[bus.mem_addr[AW-1:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
  end

  int checks = 0;
  int errors = 0;
  int nwr;
  logic mem_act;
  logic [31:0] log_addr [4];
  logic [31:0] log_data [4];
  logic [3:0]  log_mask [4];

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > 3'd2;
    return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
  endfunction

  function automatic int unsigned nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int exp_latency(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (is_illegal(we, f3)) return 1;
    return ((a % 4) + nbytes(f3) > 4) ? 3 : 2;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned cnt);
    for (int unsigned i = 0; i < cnt && i < nbytes(f3); i++)
      rb[(a + i) % NB] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < nbytes(f3); i++) v[8*i +: 8] = rb[(a + i) % NB];
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic rdy_after);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_funct3 = 3'($urandom_range(0, 7));
    nwr = 0; mem_act = 1'b0; lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        if (nwr < 4) begin
          log_addr[nwr] = bus.mem_addr; log_data[nwr] = bus.mem_wdata; log_mask[nwr] = bus.mem_wmask;
        end
        nwr++;
      end
      if (bus.mem_we || bus.mem_addr != 0 || bus.mem_wmask != 0) mem_act = 1'b1;
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    rdy_after = bus.req_ready;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
    ld_en = 1'b1;
    for (int unsigned w = 0; w < MS; w++) begin
      @(negedge clk);
      ld_idx = AW'(w); ld_val = $urandom;
      for (int unsigned b = 0; b < 4; b++) rb[4*w + b] = ld_val[8*b +: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_held: ready=%b we=%b required 0 0", bus.req_ready, bus.mem_we);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err} !== 3'b100) begin
      errors++; $display("FAIL reset_ctl: ready/valid/err=%b required 100",
                         {bus.req_ready, bus.resp_valid, bus.resp_err});
    end
    checks++;
    if (bus.resp_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
        bus.mem_wmask !== 4'd0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h mask=%b required all 0",
                         bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
  endtask

  task automatic test_aligned;
    logic [31:0] rd; logic er; int lat; logic ra;
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, ra);
    ref_store(3'd2, 32'h10, 32'hDEADBEEF, 4);
    checks++;
    if (nwr != 1 || log_addr[0] !== 32'd4 || log_mask[0] !== 4'b1111 || log_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_aligned: writes=%0d addr=%h mask=%b data=%h required 1 4 1111 deadbeef",
                         nwr, log_addr[0], log_mask[0], log_data[0]);
    end
    issue(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 2 || ra !== 1'b1 || nwr != 0) begin
      errors++; $display("FAIL lw_aligned: rdata=%h lat=%0d ready=%b writes=%0d required deadbeef 2 1 0",
                         rd, lat, ra, nwr);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat; logic ra;
    issue(1'b1, 3'd0, 32'h13, 32'h123456A5, rd, er, lat, ra);
    ref_store(3'd0, 32'h13, 32'h123456A5, 4);
    checks++;
    if (log_mask[0] !== 4'b1000 || log_data[0][31:24] !== 8'hA5 || log_addr[0] !== 32'd4) begin
      errors++; $display("FAIL sb: mask=%b lane3=%h addr=%h required 1000 a5 4",
                         log_mask[0], log_data[0][31:24], log_addr[0]);
    end
    issue(1'b0, 3'd0, 32'h13, 32'h0, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb: got %h required ffffffa5", rd); end
    issue(1'b0, 3'd4, 32'h13, 32'h0, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h000000A5) begin errors++; $display("FAIL lbu: got %h required 000000a5", rd); end
  endtask

  task automatic test_split;
    logic [31:0] rd; logic er; int lat; logic ra;
    issue(1'b1, 3'd2, 32'h06, 32'h11223344, rd, er, lat, ra);
    ref_store(3'd2, 32'h06, 32'h11223344, 4);
    checks++;
    if (nwr != 2 || log_addr[0] !== 32'd1 || log_mask[0] !== 4'b1100 || log_data[0][31:16] !== 16'h3344 ||
        log_addr[1] !== 32'd2 || log_mask[1] !== 4'b0011 || log_data[1][15:0] !== 16'h1122) begin
      errors++; $display("FAIL sw_split: n=%0d %h/%b/%h %h/%b/%h required 2 1/1100/3344xxxx 2/0011/xxxx1122",
                         nwr, log_addr[0], log_mask[0], log_data[0], log_addr[1], log_mask[1], log_data[1]);
    end
    issue(1'b0, 3'd2, 32'h06, 32'h0, rd, er, lat, ra);
    checks++;
    if (rd !== 32'h11223344 || lat != 3) begin
      errors++; $display("FAIL lw_split: rdata=%h lat=%0d required 11223344 3", rd, lat);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat; logic ra;
    issue(1'b1, 3'd1, 32'h0FFF, 32'h00008001, rd, er, lat, ra);
    ref_store(3'd1, 32'h0FFF, 32'h00008001, 4);
    checks++;
    if (nwr != 2 || log_addr[0] !== 32'd1023 || log_mask[0] !== 4'b1000 ||
        log_addr[1] !== 32'd0 || log_mask[1] !== 4'b0001) begin
      errors++; $display("FAIL sh_wrap: n=%0d %h/%b %h/%b required 2 3ff/1000 0/0001",
                         nwr, log_addr[0], log_mask[0], log_addr[1], log_mask[1]);
    end
    issue(1'b0, 3'd1, 32'h0FFF, 32'h0, rd, er, lat, ra);
    checks++;
    if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_wrap: got %h required ffff8001", rd); end
  endtask

  task automatic test_illegal;
    logic [31:0] rd; logic er; int lat; logic ra;
    logic [3:0] codes [9] = '{4'h3, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hB};
    for (int i = 0; i < 8; i++) begin
      logic [3:0] c;
      c = codes[i];
      issue(c[3], c[2:0], $urandom, $urandom, rd, er, lat, ra);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || mem_act !== 1'b0) begin
        errors++; $display("FAIL illegal we=%b f3=%0d: err=%b rdata=%h lat=%0d memact=%b required 1 0 1 0",
                           c[3], c[2:0], er, rd, lat, mem_act);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd, exp_rd; logic er, ra, we, exp_err; int lat, exp_lat, exp_nwr;
    logic [2:0] f3;
    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ld_codes[$urandom_range(0, 4)];
      a  = $urandom & 32'hFFFF_0C3F;
      wd = $urandom;
      exp_err = is_illegal(we, f3);
      exp_rd  = (!we && !exp_err) ? ref_load(f3, a) : 32'd0;
      exp_lat = exp_latency(we, f3, a);
      exp_nwr = (we && !exp_err) ? exp_lat - 1 : 0;
      issue(we, f3, a, wd, rd, er, lat, ra);
      if (we && !exp_err) ref_store(f3, a, wd, 4);
      checks++;
      if (rd !== exp_rd || er !== exp_err || lat != exp_lat || nwr != exp_nwr || ra !== 1'b1) begin
        errors++; $display("FAIL rand#%0d we=%b f3=%0d a=%h: rdata=%h err=%b lat=%0d wr=%0d rdy=%b required %h %b %0d %0d 1",
                           n, we, f3, a, rd, er, lat, nwr, ra, exp_rd, exp_err, exp_lat, exp_nwr);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] wd; logic saw_resp;
    wd = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h22; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd8) begin
      errors++; $display("FAIL rstmid_acc0: we=%b addr=%h required 1 8", bus.mem_we, bus.mem_addr);
    end
    ref_store(3'd2, 32'h22, wd, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_wmask !== 4'd0 || bus.mem_addr !== 32'd0) begin
      errors++; $display("FAIL rstmid_quiet: we=%b mask=%b addr=%h required 0 0 0",
                         bus.mem_we, bus.mem_wmask, bus.mem_addr);
    end
    saw_resp = 1'b0;
    @(negedge clk);
    if (bus.resp_valid) saw_resp = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready: got %b required 1", bus.req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    checks++;
    if (saw_resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp: resp_valid seen=%b required 0", saw_resp); end
    checks++;
    if (mem[8] !== ref_word(8) || mem[9] !== ref_word(9)) begin
      errors++; $display("FAIL rstmid_mem: w8=%h w9=%h required %h %h", mem[8], mem[9], ref_word(8), ref_word(9));
    end
  endtask

  task automatic test_final_mem;
    for (int unsigned w = 0; w < MS; w++) begin
      checks++;
      if (mem[w] !== ref_word(w)) begin
        errors++; $display("FAIL mem_word %0d: got %h required %h", w, mem[w], ref_word(w));
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_byte();
    test_split();
    test_wrap();
    test_illegal();
    test_random();
    test_reset_mid();
    test_final_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit sitting directly upstream of the data memory in the RV32 core. It accepts one load or store request at a time from the execute stage and converts the byte address, RV32I `funct3` size code and store data into word-indexed memory accesses with byte write masks. Accesses that cross a word boundary are split into two sequential word accesses. Load data is extracted, merged, and sign- or zero-extended before being returned with a one-cycle response pulse.

## Interface
- `MEM_SIZE`, 1024: memory depth in 32-bit words; power of two; word index wraps modulo `MEM_SIZE`.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I size code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse for loads and stores.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: illegal `funct3`; qualified by `resp_valid`.
- `mem_addr` out 32: word index to memory.
- `mem_wdata` out 32: byte-lane-aligned store data.
- `mem_wmask` out 4: byte write mask, bit i = bits [8i+7:8i].
- `mem_we` out 1: memory write enable.
- `mem_rdata` in 32: asynchronous memory read data, valid in the same cycle when `mem_we` = 0.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On accept, latch `we`, `funct3`, `addr`, `wdata`.
  - Illegal code goes to DONE with the error flag set. Illegal codes are loads 3, 6, 7 and stores 3–7.
  - Otherwise go to ACC0.
- Derived values:
  - off = `addr[1:0]`.
  - size = 1/2/4 bytes from `funct3[1:0]`.
  - split = off + size > 4.
  - w0 = `addr[31:2]` mod `MEM_SIZE`.
  - w1 = (w0 + 1) mod `MEM_SIZE`.
- Store lanes:
  - 64-bit D = zero-extended `wdata` << (8·off).
  - 8-bit M = size mask (0001/0011/1111) << off.
  - ACC0 drives `mem_addr` = w0, `mem_wdata` = D[31:0], `mem_wmask` = M[3:0], `mem_we` = 1.
  - ACC1 drives `mem_addr` = w1, `mem_wdata` = D[63:32], `mem_wmask` = M[7:4], `mem_we` = 1.
- Loads:
  - `mem_we` = 0 and `mem_wmask` = 0.
  - ACC0 registers `mem_rdata` as R0; ACC1 registers it as R1.
  - Result = ({R1, R0} >> 8·off) truncated to size.
  - Sign-extended for `funct3` 0/1, zero-extended for 4/5.
  - R1 is treated as 0 when not split.
- ACC0 goes to ACC1 if split, else to DONE. ACC1 goes to DONE.
- **DONE**
  - `resp_valid` = 1 for exactly one cycle.
  - `resp_rdata` and `resp_err` driven from registers.
  - Next state is IDLE.
  - `req_valid` is ignored while in DONE.
- Outside ACC0/ACC1: `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_we` all 0.
- The misaligned split is mandatory; no misaligned trap is raised.

## Timing
- Cycle 0 is the accept edge.
- Aligned, non-split access:
  - ACC0 in cycle 1, `resp_valid` in cycle 2.
  - Next accept possible in cycle 3.
- Split access: ACC0 in cycle 1, ACC1 in cycle 2, `resp_valid` in cycle 3.
- Illegal `funct3`: `resp_valid` in cycle 1, `resp_err` = 1, no memory activity.
- Memory outputs are combinational from state and latched request only, never from `req_*` directly.
- Memory outputs are forced to 0 whenever `rst` = 0, so no write commits on a reset edge.
- Reset values:
  - State IDLE; `req_ready` = 1 after reset releases, 0 while `rst` = 0.
  - `resp_valid`, `resp_err` = 0.
  - `resp_rdata`, R0, R1 = 0.
  - All `mem_*` = 0.
- Reset mid-operation: in-flight request is dropped with no response. A first half already written in ACC0 stays written; the second half is not issued.
- Wrap-around: a split access at word `MEM_SIZE-1` uses w1 = 0.

## Test plan
- SW 0xDEADBEEF to byte addr 0x10, then LW 0x10:
  - Store: one write, `mem_addr` = 4, `mem_wmask` = 1111.
  - Load: `resp_rdata` = 0xDEADBEEF, `resp_valid` 2 cycles after accept.
- SB 0xA5 to addr 0x13, then LB and LBU at 0x13:
  - Store: `mem_wmask` = 1000, `mem_wdata[31:24]` = 0xA5.
  - LB returns 0xFFFFFFA5; LBU returns 0x000000A5.
- SW 0x11223344 to addr 0x06, then LW 0x06:
  - Store: word 1 mask 1100 with lanes 0x3344----, then word 2 mask 0011 with lanes ----1122.
  - Load: `resp_rdata` = 0x11223344 in cycle 3.
- SH 0x8001 to addr 0x0FFF with `MEM_SIZE` = 1024:
  - Word 1023 written with mask 1000; word 0 written with mask 0001.
  - LH 0x0FFF returns 0xFFFF8001.
- Load with `funct3` = 3:
  - `resp_valid` with `resp_err` = 1 and `resp_rdata` = 0 one cycle after accept.
  - `mem_we` and `mem_addr` stay 0 throughout.
- Split store, `rst` driven 0 during the ACC1 cycle:
  - Only word w0 modified; no `resp_valid`.
  - `req_ready` = 1 on the first cycle after `rst` returns to 1.
